// File: rtl/rx_column_loader_ne.sv
// rx_column_loader_ne: captures FIFO words into a LOADCOUNT-column receive
// table and checks that every column arrived. On the rising edge of done it
// either starts the decoder with a one-cycle decode_start, or flags
// load_error and discards the frame. While the decoder runs, the table stays
// locked until decode_done. Writes that arrive while the table is locked
// set overrun_error. Writes to an address outside the table set load_error.
// Optional: define RX_LOADER_DUP_DETECT_EN to flag a second write to a
// column that is already loaded (dup_error). When the macro is undefined,
// dup_error is tied to 0.
module rx_column_loader_ne #(
  parameter int ADDRESSWIDTH = 9,
  parameter int LOADCOUNT    = 17,
  parameter int DATAWIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_en,
  input  logic [ADDRESSWIDTH-1:0]        LOADADDRESS,
  input  logic [DATAWIDTH-1:0]           fifo_dout,
  input  logic                           done,
  input  logic                           decode_done,
  input  logic                           err_clr,
  output logic [LOADCOUNT*DATAWIDTH-1:0] rxtable,
  output logic                           table_valid,
  output logic                           decode_start,
  output logic [LOADCOUNT-1:0]           col_mask,
  output logic                           load_error,
  output logic                           overrun_error,
  output logic                           dup_error
);

  typedef enum logic [1:0] {IDLE, LOADING, START, DECODING} state_t;

  state_t               state, state_nxt;
  logic                 done_d, done_rise, open_st, addr_ok, complete;
  logic                 lerr_set, ovr_set;
  logic [LOADCOUNT-1:0] hit, mask_nxt;

  assign done_rise = done & ~done_d;
  assign open_st   = (state == IDLE) || (state == LOADING);
  assign addr_ok   = LOADADDRESS < ADDRESSWIDTH'(LOADCOUNT);
  // The completeness check includes any write landing in the same cycle.
  assign mask_nxt  = col_mask | hit;
  assign complete  = &mask_nxt;

  // Per-column write decode and storage.
  for (genvar k = 0; k < LOADCOUNT; k++) begin : g_col
    assign hit[k] = load_en & open_st & addr_ok &
                    (LOADADDRESS == ADDRESSWIDTH'(k));

    // Column register: reset clears it, and an accepted write replaces it.
    always_ff @(posedge clk) begin
      if (rst)         rxtable[k*DATAWIDTH +: DATAWIDTH] <= '0;
      else if (hit[k]) rxtable[k*DATAWIDTH +: DATAWIDTH] <= fifo_dout;
    end
  end

  // State register and done edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done_d <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_d <= done;
    end
  end

  // Next-state logic, decoder handshake outputs and error set conditions.
  always_comb begin
    state_nxt    = state;
    decode_start = 1'b0;
    table_valid  = 1'b0;
    lerr_set     = load_en & ~addr_ok;
    ovr_set      = load_en & ~open_st;
    case (state)
      IDLE, LOADING: begin
        if (done_rise) begin
          if (complete) state_nxt = START;
          else begin
            lerr_set  = 1'b1;
            state_nxt = IDLE;
          end
        end else if (|hit) begin
          state_nxt = LOADING;
        end
      end
      START: begin
        decode_start = 1'b1;
        table_valid  = 1'b1;
        state_nxt    = DECODING;
      end
      DECODING: begin
        table_valid = 1'b1;
        if (decode_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Column-loaded mask. It is dropped when a frame is incomplete or when the
  // decoder finishes.
  always_ff @(posedge clk) begin
    if (rst)                                col_mask <= '0;
    else if (open_st)                       col_mask <= (done_rise && !complete) ? '0 : mask_nxt;
    else if (state == DECODING && decode_done) col_mask <= '0;
  end

  // Sticky error flags. A new error in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_error    <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      load_error    <= lerr_set | (load_error    & ~err_clr);
      overrun_error <= ovr_set  | (overrun_error & ~err_clr);
    end
  end

`ifdef RX_LOADER_DUP_DETECT_EN
  logic dup_set;
  assign dup_set = |(hit & col_mask);

  // Duplicate-write flag. The write itself still lands, so the last write wins.
  always_ff @(posedge clk) begin
    if (rst) dup_error <= 1'b0;
    else     dup_error <= dup_set | (dup_error & ~err_clr);
  end
`else
  assign dup_error = 1'b0;
`endif

endmodule

// File: tb/tb_rx_column_loader_ne.sv
// tb_rx_column_loader_ne: directed and randomized frames for
// rx_column_loader_ne. The model tracks the table as an array, tracks the
// loaded set, and tracks a frame phase (open / start / decoding). It is
// updated from the behavioural rules once per clock.
module tb_rx_column_loader_ne;
  localparam int AW = 9, LC = 17, DW = 16, TW = LC * DW;

  logic              clk = 1'b0;
  logic              rst, load_en, done, decode_done, err_clr;
  logic [AW-1:0]     LOADADDRESS;
  logic [DW-1:0]     fifo_dout;
  logic [TW-1:0]     rxtable;
  logic              table_valid, decode_start, load_error, overrun_error, dup_error;
  logic [LC-1:0]     col_mask;

  rx_column_loader_ne #(.ADDRESSWIDTH(AW), .LOADCOUNT(LC), .DATAWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .LOADADDRESS(LOADADDRESS),
    .fifo_dout(fifo_dout), .done(done), .decode_done(decode_done),
    .err_clr(err_clr), .rxtable(rxtable), .table_valid(table_valid),
    .decode_start(decode_start), .col_mask(col_mask), .load_error(load_error),
    .overrun_error(overrun_error), .dup_error(dup_error)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model state.
  logic [LC-1:0][DW-1:0] m_tab;
  logic [LC-1:0]         m_mask;
  int                    m_phase;   // 0 open, 1 start pulse, 2 decoding
  bit                    m_done_d, m_lerr, m_oerr, m_derr;

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit r, input bit le, input int a, input logic [DW-1:0] d,
                      input bit dn, input bit dd, input bit ec);
    int op;
    bit rise, ls, os, ds;
    rst = r; load_en = le; LOADADDRESS = AW'(a); fifo_dout = d;
    done = dn; decode_done = dd; err_clr = ec;
    op = m_phase; rise = dn && !m_done_d; ls = 0; os = 0; ds = 0;
    if (r) begin
      m_tab = '0; m_mask = '0; m_phase = 0; m_done_d = 0;
      m_lerr = 0; m_oerr = 0; m_derr = 0;
    end else begin
      m_done_d = dn;
      if (le) begin
        if (a >= LC) ls = 1;
        if (op != 0) os = 1;
        else if (a < LC) begin
          if (m_mask[a]) ds = 1;
          m_tab[a]  = d;
          m_mask[a] = 1'b1;
        end
      end
      if (op == 0 && rise) begin
        if (&m_mask) m_phase = 1;
        else begin ls = 1; m_mask = '0; end
      end else if (op == 1) m_phase = 2;
      else if (op == 2 && dd) begin m_phase = 0; m_mask = '0; end
`ifndef RX_LOADER_DUP_DETECT_EN
      ds = 0;
`endif
      m_lerr = ls | (m_lerr & !ec);
      m_oerr = os | (m_oerr & !ec);
      m_derr = ds | (m_derr & !ec);
    end
    @(posedge clk); #1;
    chk("rxtable", rxtable, m_tab);
    chk("col_mask", TW'(col_mask), TW'(m_mask));
    chk("table_valid", TW'(table_valid), TW'(m_phase != 0));
    chk("decode_start", TW'(decode_start), TW'(m_phase == 1));
    chk("load_error", TW'(load_error), TW'(m_lerr));
    chk("overrun_error", TW'(overrun_error), TW'(m_oerr));
    chk("dup_error", TW'(dup_error), TW'(m_derr));
  endtask

  task automatic idle(input int n, input bit dn);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, dn, 0, 0);
  endtask

  initial begin
    int ord[LC];
    int skip, hl, tmp, j;

    // Reset
    step(1, 0, 0, '0, 0, 0, 0);
    step(1, 0, 0, '0, 0, 0, 0);
    chk("reset_rxtable", rxtable, '0);

    // Full frame, then done held high for 10 cycles
    for (int a = 0; a < LC; a++) step(0, 1, a, 16'(16'h1000 + a), 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    chk("first_start", TW'(decode_start), TW'(1'b1));
    step(0, 0, 0, '0, 1, 0, 0);
    chk("start_single", TW'(decode_start), TW'(1'b0));
    chk("mask_full", TW'(col_mask), TW'(17'h1FFFF));
    chk("col5", TW'(rxtable[5*DW +: DW]), TW'(16'h1005));
    idle(8, 1);
    idle(2, 0);
    // Overrun while decoding
    step(0, 1, 3, 16'hBEEF, 0, 0, 0);
    chk("col3_kept", TW'(rxtable[3*DW +: DW]), TW'(16'h1003));
    chk("overrun_set", TW'(overrun_error), TW'(1'b1));
    step(0, 0, 0, '0, 0, 1, 0);
    chk("valid_drop", TW'(table_valid), TW'(1'b0));
    step(0, 0, 0, '0, 0, 0, 1);

    // Incomplete frame (column 9 missing)
    for (int a = 0; a < LC; a++) if (a != 9) step(0, 1, a, 16'(16'h2000 + a), 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    chk("incomplete_err", TW'(load_error), TW'(1'b1));
    chk("incomplete_mask", TW'(col_mask), '0);
    idle(3, 1);
    idle(1, 0);

    // Out-of-range address, then err_clr on the next cycle
    step(0, 0, 0, '0, 0, 0, 1);
    step(0, 1, 17, 16'hDEAD, 0, 0, 0);
    chk("oor_err", TW'(load_error), TW'(1'b1));
    step(0, 0, 0, '0, 0, 0, 1);
    chk("oor_clr", TW'(load_error), TW'(1'b0));

    // Last column written in the same cycle that done rises
    for (int a = 0; a < LC - 1; a++) step(0, 1, a, 16'(16'h3000 + a), 0, 0, 0);
    step(0, 1, 16, 16'hC016, 1, 0, 0);
    chk("same_cycle_start", TW'(decode_start), TW'(1'b1));
    chk("col16", TW'(rxtable[16*DW +: DW]), TW'(16'hC016));
    idle(2, 0);
    step(0, 0, 0, '0, 0, 1, 0);

    // Duplicate write to column 2
    step(0, 1, 2, 16'h0001, 0, 0, 0);
    step(0, 1, 2, 16'h0002, 0, 0, 0);
    chk("col2_last", TW'(rxtable[2*DW +: DW]), TW'(16'h0002));
`ifdef RX_LOADER_DUP_DETECT_EN
    chk("dup_flag", TW'(dup_error), TW'(1'b1));
`else
    chk("dup_flag", TW'(dup_error), TW'(1'b0));
`endif
    // Reset in the middle of a frame
    step(1, 0, 0, '0, 0, 0, 0);
    idle(1, 0);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < LC; i++) ord[i] = i;
      for (int i = LC - 1; i > 0; i--) begin
        j = int'($urandom_range(0, i)); tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
      skip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LC - 1)) : -1;
      for (int i = 0; i < LC; i++) begin
        if (ord[i] != skip) step(0, 1, ord[i], 16'($urandom), 0, 0, 0);
        if ($urandom_range(0, 5) == 0)
          step(0, 0, 0, '0, 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        if ($urandom_range(0, 15) == 0)
          step(0, 1, int'($urandom_range(LC, 511)), 16'($urandom), 0, 0, 0);
        if ($urandom_range(0, 15) == 0)
          step(0, 1, int'($urandom_range(0, LC - 1)), 16'($urandom), 0, 0, 0);
      end
      if ($urandom_range(0, 9) == 0) step(1, 0, 0, '0, 0, 0, 0);
      hl = int'($urandom_range(1, 12));
      for (int i = 0; i < hl; i++) step(0, 0, 0, '0, 1, 0, $urandom_range(0, 4) == 0);
      step(0, 0, 0, '0, 0, 0, 0);
      if ($urandom_range(0, 2) == 0)
        step(0, 1, int'($urandom_range(0, LC - 1)), 16'($urandom), 0, 0, 0);
      if ($urandom_range(0, 7) == 0) step(1, 0, 0, '0, 0, 0, 0);
      idle(int'($urandom_range(0, 4)), 0);
      step(0, 0, 0, '0, 0, 1, 0);
      step(0, 0, 0, '0, 0, 0, $urandom_range(0, 1) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
